// File: rtl/aurora_axi_pkg.sv
// Shared widths, FIFO depth, FSM encoding and the buffered beat layout
// for the Aurora AXI-Stream TX demultiplexer.
package aurora_axi_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned KEEP_W     = 4;
    localparam int unsigned TAG_W      = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } pkt_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [TAG_W-1:0]  tag;
    } beat_t;

endpackage

// File: rtl/aurora_axis_skid.sv
// Two-entry beat FIFO with a registered input ready; the head entry is held
// stable until it is popped.
module aurora_axis_skid
    import aurora_axi_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  in_ready,
    output logic  out_valid,
    output beat_t out_beat,
    input  logic  out_pop
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0] count_q, count_d;
    beat_t            head_q, head_d;
    beat_t            tail_q, tail_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    always_comb begin
        push    = in_valid & ready_q;
        pop     = out_pop & (count_q != '0);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (pop) begin
            head_d = tail_q;
        end
        // The new beat lands at the head only if the head slot is (or becomes) free.
        if (push) begin
            if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
                head_d = in_beat;
            end else begin
                tail_d = in_beat;
            end
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (count_q != '0);
    assign out_beat  = head_q;

endmodule

// File: rtl/aurora_axi_tx_demux.sv
// Routes AXI-Stream packets to one of ETHCOUNT downstream channels, selected at
// the first beat; packets tagged for a non-existent channel are drained and counted.
module aurora_axi_tx_demux
    import aurora_axi_pkg::*;
#(
    parameter int ETHCOUNT = 4,
    parameter int SIM      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 axis_m_sel,
    output logic                       axis_s_tready,
    input  logic [31:0]                axis_s_tdata,
    input  logic [3:0]                 axis_s_tkeep,
    input  logic                       axis_s_tvalid,
    input  logic                       axis_s_tlast,
    input  logic [ETHCOUNT-1:0]        axis_m_tready,
    output logic [ETHCOUNT*32-1:0]     axis_m_tdata,
    output logic [ETHCOUNT*4-1:0]      axis_m_tkeep,
    output logic [ETHCOUNT-1:0]        axis_m_tvalid,
    output logic [ETHCOUNT-1:0]        axis_m_tlast,
    output logic [15:0]                drop_cnt,
    output logic                       busy
);

    if (ETHCOUNT < 1 || ETHCOUNT > 8) begin : g_bad_ethcount
        $error("aurora_axi_tx_demux: ETHCOUNT must be in 1..8");
    end

    pkt_state_e       state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    beat_t            in_beat, head;
    logic             fifo_ready, fifo_valid, fifo_pop;
    logic             accept, head_in_range, head_ready;

    assign accept = axis_s_tvalid & fifo_ready;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;

        in_beat.data = axis_s_tdata;
        in_beat.keep = axis_s_tkeep;
        in_beat.last = axis_s_tlast;
        in_beat.tag  = (state_q == ST_IDLE) ? axis_m_sel : tag_q;

        if (accept) begin
            if (state_q == ST_IDLE) begin
                tag_d = axis_m_sel;
            end
            state_d = axis_s_tlast ? ST_IDLE : ST_FWD;
        end
    end

    aurora_axis_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (axis_s_tvalid),
        .in_beat   (in_beat),
        .in_ready  (fifo_ready),
        .out_valid (fifo_valid),
        .out_beat  (head),
        .out_pop   (fifo_pop)
    );

    for (genvar i = 0; i < ETHCOUNT; i++) begin : g_ch
        assign axis_m_tvalid[i]               = fifo_valid && (head.tag == TAG_W'(i));
        assign axis_m_tdata[i*DATA_W +: DATA_W] = head.data;
        assign axis_m_tkeep[i*KEEP_W +: KEEP_W] = head.keep;
        assign axis_m_tlast[i]                = head.last;
    end

    // Out-of-range tags never raise a tvalid, so they drain at one beat per cycle.
    always_comb begin
        head_in_range = (32'(head.tag) < 32'(ETHCOUNT));
        head_ready    = |(axis_m_tvalid & axis_m_tready);
        fifo_pop      = fifo_valid & (head_ready | ~head_in_range);

        drop_cnt_d = drop_cnt_q;
        if (fifo_valid && !head_in_range && head.last && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign axis_s_tready = fifo_ready;
    assign drop_cnt      = drop_cnt_q;
    assign busy          = (state_q == ST_FWD) | fifo_valid;

    if (SIM != 0) begin : g_sim_checks
        assert property (@(posedge clk) disable iff (rst)
            (fifo_valid && !fifo_pop) |=> $stable(head));
    end

endmodule
